// File: rtl/masku_mask_compressor_if.sv
// Interface bundling the configuration, beat input and mask-word output
// channels of the mask compressor. The master side drives configuration,
// beats and out_ready; the slave side is the compressor itself.
interface masku_mask_compressor_if #(
    parameter int DW  = 256,
    parameter int VlW = 15
);
    logic            start;
    logic [VlW-1:0]  vl;
    logic [1:0]      vsew;
    logic            vm;
    logic            busy;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [DW-1:0]   in_mask;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [DW-1:0]   out_bit_en;
    logic            out_last;

    modport master (
        output start, vl, vsew, vm, in_valid, in_data, in_mask, out_ready,
        input  busy, in_ready, out_valid, out_data, out_bit_en, out_last
    );

    modport slave (
        input  start, vl, vsew, vm, in_valid, in_data, in_mask, out_ready,
        output busy, in_ready, out_valid, out_data, out_bit_en, out_last
    );
endinterface

// File: rtl/masku_mask_compressor.sv
// Streaming SEW->1-bit compressor: takes result beats holding one result bit
// in each element LSB, packs them into DW-bit mask words and emits each word
// with a per-bit write enable covering the vl tail and vm masking.
module masku_mask_compressor #(
    parameter int NrLanes = 4,
    parameter int MaxVl   = 16384,
    parameter int ELEN    = 64
) (
    input  logic clk,
    input  logic rst,
    masku_mask_compressor_if.slave bus
);
    localparam int DW      = NrLanes * ELEN;
    localparam int PTR_W   = $clog2(DW);
    localparam int VlW     = $clog2(MaxVl + 1);
    localparam int CNT_W   = VlW + 1;
    localparam int MAX_EPB = DW / 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    state_e            state_r;
    logic [VlW-1:0]    vl_r;
    logic [1:0]        vsew_r;
    logic              vm_r;
    logic [CNT_W-1:0]  elem_cnt_r;
    logic [PTR_W-1:0]  bit_ptr_r;
    logic [DW-1:0]     acc_data_r;
    logic [DW-1:0]     acc_en_r;
    logic              out_valid_r;
    logic              out_last_r;
    logic [DW-1:0]     out_data_r;
    logic [DW-1:0]     out_en_r;

    logic [PTR_W:0]    epb_s;
    logic [CNT_W-1:0]  vl_ext_s;
    logic              in_ready_s;
    logic              beat_fire_s;
    logic              fill_s;
    logic              last_beat_s;
    logic [CNT_W-1:0]  cnt_next_s;
    logic [PTR_W-1:0]  ptr_next_s;
    logic [DW-1:0]     word_data_s;
    logic [DW-1:0]     word_en_s;
    logic              elem_ok_s;
    logic              elem_en_s;
    logic [PTR_W-1:0]  pos_s;

    // A beat may enter only while accumulating and when the output register
    // is free or being freed in this same cycle (no bubble on handover).
    assign in_ready_s  = (state_r == ST_ACCUM) && (!out_valid_r || bus.out_ready);
    assign beat_fire_s = bus.in_valid && in_ready_s;
    assign vl_ext_s    = {1'b0, vl_r};

    assign bus.busy       = (state_r != ST_IDLE);
    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_last   = out_last_r;
    assign bus.out_data   = out_data_r;
    assign bus.out_bit_en = out_en_r;

    // Merge the current beat into a copy of the accumulator. Positions the
    // beat touches are still zero in the accumulator, so OR-merging is exact;
    // lanes beyond EPB or beyond vl contribute nothing.
    always_comb begin
        epb_s       = (PTR_W + 1)'(DW) >> (3'd3 + {1'b0, vsew_r});
        fill_s      = (({1'b0, bit_ptr_r} + epb_s) >= (PTR_W + 1)'(DW));
        last_beat_s = ((elem_cnt_r + CNT_W'(epb_s)) >= vl_ext_s);
        cnt_next_s  = last_beat_s ? vl_ext_s : (elem_cnt_r + CNT_W'(epb_s));
        ptr_next_s  = bit_ptr_r + PTR_W'(epb_s);
        word_data_s = acc_data_r;
        word_en_s   = acc_en_r;
        elem_ok_s   = 1'b0;
        elem_en_s   = 1'b0;
        pos_s       = '0;
        for (int e = 0; e < MAX_EPB; e++) begin
            elem_ok_s = (e < int'(epb_s)) && ((elem_cnt_r + CNT_W'(e)) < vl_ext_s);
            elem_en_s = elem_ok_s & (vm_r | bus.in_mask[e]);
            pos_s     = bit_ptr_r + PTR_W'(e);
            word_en_s[pos_s]   = word_en_s[pos_s] | elem_en_s;
            word_data_s[pos_s] = word_data_s[pos_s] |
                (elem_en_s & bus.in_data[PTR_W'(e << (3 + int'(vsew_r)))]);
        end
    end

    // Control FSM, packing state and registered output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            vl_r        <= '0;
            vsew_r      <= 2'd0;
            vm_r        <= 1'b0;
            elem_cnt_r  <= '0;
            bit_ptr_r   <= '0;
            acc_data_r  <= '0;
            acc_en_r    <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_data_r  <= '0;
            out_en_r    <= '0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (bus.start && (bus.vl != VlW'(0))) begin
                        vl_r       <= bus.vl;
                        vsew_r     <= bus.vsew;
                        vm_r       <= bus.vm;
                        elem_cnt_r <= '0;
                        bit_ptr_r  <= '0;
                        acc_data_r <= '0;
                        acc_en_r   <= '0;
                        state_r    <= ST_ACCUM;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_ACCUM, ST_DRAIN: begin
                    if (out_valid_r && bus.out_ready) begin
                        out_valid_r <= 1'b0;
                        out_last_r  <= 1'b0;
                        if (out_last_r) begin
                            state_r <= ST_IDLE;
                        end else begin
                            state_r <= state_r;
                        end
                    end else begin
                        out_valid_r <= out_valid_r;
                    end
                    // A new beat overrides the clear above when it completes a word.
                    if (beat_fire_s) begin
                        elem_cnt_r <= cnt_next_s;
                        if (fill_s || last_beat_s) begin
                            out_valid_r <= 1'b1;
                            out_last_r  <= last_beat_s;
                            out_data_r  <= word_data_s;
                            out_en_r    <= word_en_s;
                            acc_data_r  <= '0;
                            acc_en_r    <= '0;
                            bit_ptr_r   <= '0;
                        end else begin
                            acc_data_r  <= word_data_s;
                            acc_en_r    <= word_en_s;
                            bit_ptr_r   <= ptr_next_s;
                        end
                        if (last_beat_s) begin
                            state_r <= ST_DRAIN;
                        end else begin
                            state_r <= ST_ACCUM;
                        end
                    end else begin
                        elem_cnt_r <= elem_cnt_r;
                    end
                end
                default: begin
                    state_r     <= ST_IDLE;
                    out_valid_r <= 1'b0;
                    out_last_r  <= 1'b0;
                end
            endcase
        end
    end
endmodule
